// File: rtl/dm_pkg.sv
// Data-memory responder shared definitions.
// Access-type codes, FSM states and decode helpers.
package dm_pkg;

  localparam logic [3:0] LSOP_NONE = 4'b0000;
  localparam logic [3:0] LSOP_LW   = 4'b0001;
  localparam logic [3:0] LSOP_LH   = 4'b0010;
  localparam logic [3:0] LSOP_LHU  = 4'b0011;
  localparam logic [3:0] LSOP_LB   = 4'b0100;
  localparam logic [3:0] LSOP_LBU  = 4'b0101;
  localparam logic [3:0] LSOP_SW   = 4'b0110;
  localparam logic [3:0] LSOP_SH   = 4'b0111;
  localparam logic [3:0] LSOP_SB   = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MAX_LATENCY = 15;

  function automatic logic is_store(input logic [3:0] op);
    return (op == LSOP_SW) || (op == LSOP_SH) || (op == LSOP_SB);
  endfunction

  // Invalid opcode or misaligned for the access size.
  function automatic logic lsop_err(
    input logic [3:0] op,
    input logic [1:0] off
  );
    logic e;
    e = 1'b1;
    unique case (1'b1)
      op == LSOP_LW,
      op == LSOP_SW:  e = (off != 2'b00);
      op == LSOP_LH,
      op == LSOP_LHU,
      op == LSOP_SH:  e = off[0];
      op == LSOP_LB,
      op == LSOP_LBU,
      op == LSOP_SB:  e = 1'b0;
      default:        e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load data extraction: selects byte/half/word from the
// addressed memory word and sign- or zero-extends it.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [3:0]  lsop,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  bsel;

  always_comb begin
    half = off[1] ? word[31:16] : word[15:0];
    bsel = word[7:0];
    unique case (off)
      2'd0: bsel = word[7:0];
      2'd1: bsel = word[15:8];
      2'd2: bsel = word[23:16];
      2'd3: bsel = word[31:24];
      default: bsel = word[7:0];
    endcase
    data = '0;
    unique case (1'b1)
      lsop == LSOP_LW:  data = word;
      lsop == LSOP_LH:  data = {{16{half[15]}}, half};
      lsop == LSOP_LHU: data = {16'h0, half};
      lsop == LSOP_LB:  data = {{24{bsel[7]}}, bsel};
      lsop == LSOP_LBU: data = {24'h0, bsel};
      default:          data = '0;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Fixed-latency data RAM answering M-stage loads and stores
// with one response per accepted request.
module dm_responder
  import dm_pkg::*;
#(
  parameter int WORD_AW = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_lsop,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 2 ** WORD_AW;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [3:0]  lsop_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        fire;
  logic [31:0] cur_addr;
  logic [3:0]  cur_lsop;
  logic [3:0]  cur_be;
  logic [31:0] cur_wd;
  logic [WORD_AW-1:0] idx;
  logic        oor;
  logic        bad;
  logic        store;
  logic [31:0] ld_data;

  assign req_ready = !reset && (state != BUSY);
  assign accept    = req_valid && req_ready;

  // With single-cycle latency the response edge is the accept edge,
  // so the request is taken straight from the ports.
  assign cur_addr = (LATENCY == 1) ? req_addr   : addr_q;
  assign cur_lsop = (LATENCY == 1) ? req_lsop   : lsop_q;
  assign cur_be   = (LATENCY == 1) ? req_byteen : be_q;
  assign cur_wd   = (LATENCY == 1) ? req_wdata  : wd_q;

  assign fire = (LATENCY == 1) ? accept
              : (state == BUSY) && (cnt == 4'd1);

  assign idx   = cur_addr[WORD_AW+1:2];
  assign oor   = (cur_addr >> (WORD_AW + 2)) != 32'd0;
  assign bad   = oor || lsop_err(cur_lsop, cur_addr[1:0]);
  assign store = is_store(cur_lsop);

  dm_load_ext u_ext (
    .word (mem[idx]),
    .off  (cur_addr[1:0]),
    .lsop (cur_lsop),
    .data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      if (accept) begin
        addr_q <= req_addr;
        lsop_q <= req_lsop;
        be_q   <= req_byteen;
        wd_q   <= req_wdata;
      end
      unique case (state)
        IDLE, RESP: begin
          if (!accept) begin
            state <= IDLE;
          end else if (LATENCY == 1) begin
            state <= RESP;
          end else begin
            state <= BUSY;
            cnt   <= LAT_M1;
          end
        end
        BUSY: begin
          if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if (fire) begin
        resp_valid <= 1'b1;
        resp_err   <= bad;
        resp_rdata <= (bad || store) ? 32'd0 : ld_data;
        if (store && !bad) begin
          for (int b = 0; b < 4; b++) begin
            if (cur_be[b]) mem[idx][8*b +: 8] <= cur_wd[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the memory-side end of the M-stage store/load interface.
- Accepts one request at a time with a valid/ready handshake. Stores are committed by byte enable. Loads return the byte, half or word, sign- or zero-extended.
- Sits between the CPU M stage and W-stage writeback. Models a fixed-latency data RAM.

Parameters:
- WORD_AW, 12, word-address width; memory depth is 2**WORD_AW 32-bit words.
- LATENCY, 2, cycles from the accept edge to resp_valid; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  32  byte address.
- req_lsop  input  4  access type: NONE=0000, LW=0001, LH=0010, LHU=0011, LB=0100, LBU=0101, SW=0110, SH=0111, SB=1000.
- req_byteen  input  4  store lane enables, already lane-shifted by the initiator.
- req_wdata  input  32  store data, already lane-shifted by the initiator.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned access, out-of-range access, or invalid lsop; qualified by resp_valid.

Behaviour:
- States: IDLE, BUSY, RESP.
- req_ready = 1 in IDLE and in RESP; 0 in BUSY and while reset is high.
- Accept occurs on an edge where req_valid && req_ready. The edge registers addr, lsop, byteen and wdata.
- LATENCY=1: accept → RESP.
- LATENCY>1: accept → BUSY, counter loaded with LATENCY-1; the counter decrements each cycle; at count 1 the next state is RESP.
- RESP lasts exactly one cycle. resp_valid=1 only in RESP. Next state is BUSY/RESP on a new accept, otherwise IDLE.
- Back-to-back requests therefore give one response every LATENCY cycles, with no idle gap.
- Error check, evaluated on the captured request:
  - LW/SW with addr[1:0]≠0 → error.
  - LH/LHU/SH with addr[0]≠0 → error.
  - Any addr[31:WORD_AW+2]≠0 → error.
  - lsop NONE or 1001..1111 → error.
- Store commit: memory is written on the edge that enters RESP, only when there is no error. Lanes are written where byteen[i]=1. byteen=0000 on a store means no write and no error.
- Load read: the word is read from the array on the same edge, so a load always sees every earlier committed store.
- Load extraction, with the selected word W:
  - LW → W.
  - LH/LHU → W[31:16] if addr[1], else W[15:0]; sign- or zero-extended.
  - LB/LBU → byte addr[1:0]; sign- or zero-extended.
- Word index is addr[WORD_AW+1:2].
- resp_rdata and resp_err are held at 0 outside RESP.
- Reset:
  - state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - All memory words are cleared to 0.
  - Reset mid-BUSY aborts the request: no response, and a pending store is never committed.
  - Reset on the RESP-entry edge wins over the commit.
- req_byteen and req_wdata are ignored for loads. req_lsop, not byteen, classifies the access.

Decomposition:
- Package dm_pkg holds:
  - lsop localparams (LSOP_NONE..LSOP_SB);
  - the state encoding (IDLE/BUSY/RESP);
  - a function/constant for the maximum LATENCY.
- One combinational sub-module, dm_load_ext, takes the word, addr[1:0] and lsop and produces the extended 32-bit value. The FSM, counter, error check and array stay in dm_responder.

Test Plan:
- Reset, then SW addr 0x10, byteen 1111, wdata 0xDEADBEEF; then LW 0x10 → resp_valid exactly LATENCY cycles after each accept, rdata 0x00000000 for the SW, 0xDEADBEEF for the LW, err 0.
- After that word: LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x10 → 0xFFFFBEEF; LHU 0x12 → 0x0000DEAD.
- SB 0x11, byteen 0010, wdata 0x00005500; then LW 0x10 → 0xDEAD55EF. SH 0x12, byteen 1100, wdata 0x12340000; then LW → 0x123455EF.
- LW 0x11 and SH 0x13 (store data 0xFFFFFFFF) → resp_err=1, rdata 0; a following LW 0x10 shows memory unchanged. Address 0x00010000 with WORD_AW=12 → err=1.
- req_valid held high with 4 requests, LATENCY=2 → req_ready low in BUSY, resp_valid on cycles 2, 4, 6, 8 after the first accept; LATENCY=1 → resp_valid every cycle.
- SW 0x20 of 0xCAFEF00D, then reset asserted in BUSY (LATENCY=3) → no resp_valid; after reset, LW 0x20 → 0x00000000, req_ready=1 in the first cycle after reset deasserts.
